// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, req/ack imem read, instruction register split into fields.
// Define FETCH_TIMEOUT_EN to add a sticky fetch-timeout error state (S_ERR, exits only on reset).
module fetch_stage #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_c_branch,
    input  logic [31:0] i_branch_target,
    input  logic        i_c_jump,
    input  logic [31:0] i_jump_target,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_instr,
    output logic [5:0]  o_opcode,
    output logic [4:0]  o_Rs,
    output logic [4:0]  o_Rt,
    output logic [4:0]  o_Rd,
    output logic [5:0]  o_funct,
    output logic [15:0] o_imm16,
    output logic        o_fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_OUT
`ifdef FETCH_TIMEOUT_EN
        , S_ERR
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] instr, instr_nxt;
    logic [31:0] redirect_pc;

    // Jump beats branch; targets are word-aligned by dropping the low two bits.
    always_comb begin
        if (i_c_jump)        redirect_pc = i_jump_target & ~32'd3;
        else if (i_c_branch) redirect_pc = i_branch_target & ~32'd3;
        else                 redirect_pc = pc + 32'd4;
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt, to_cnt_nxt;
    logic          to_expire;
    assign to_expire = (32'(to_cnt) + 32'd1 >= 32'(TIMEOUT_CYCLES));
`endif

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        instr_nxt  = instr;
        o_imem_req = 1'b0;
        o_valid    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        to_cnt_nxt = '0;
`endif
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                o_imem_req = 1'b1;
                if (i_imem_ack) begin
                    instr_nxt = i_imem_rdata;
                    state_nxt = S_OUT;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (to_expire) state_nxt = S_ERR;
                else                to_cnt_nxt = to_cnt + 1'b1;
`endif
            end
            S_OUT: begin
                o_valid = 1'b1;
                if (!i_stall) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = S_REQ;
                end
            end
`ifdef FETCH_TIMEOUT_EN
            S_ERR: state_nxt = S_ERR;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            instr  <= '0;
`ifdef FETCH_TIMEOUT_EN
            to_cnt <= '0;
`endif
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            instr  <= instr_nxt;
`ifdef FETCH_TIMEOUT_EN
            to_cnt <= to_cnt_nxt;
`endif
        end
    end

`ifdef FETCH_TIMEOUT_EN
    assign o_fetch_err = (state == S_ERR);
`else
    assign o_fetch_err = 1'b0;
`endif

    assign o_imem_addr = pc & ~32'd3;
    assign o_pc        = pc;
    assign o_pc_plus4  = pc + 32'd4;
    assign o_instr     = instr;
    assign o_opcode    = instr[31:26];
    assign o_Rs        = instr[25:21];
    assign o_Rt        = instr[20:16];
    assign o_Rd        = instr[15:11];
    assign o_funct     = instr[5:0];
    assign o_imm16     = instr[15:0];

endmodule
